// File: rtl/ticket_arbiter.sv
// ticket_arbiter
//   Ticket-lock arbiter: a ticket dispenser plus a now-serving counter grant
//   one shared resource to HIPROC+1 requesters in strict arrival order.
//   At most one grant bit is ever high.
//
//   Optional feature macro: GRANT_TIMEOUT_EN
//     defined   -> hold watchdog forces release after 2**(HOLDMSB+1)-1
//                  grant cycles and pulses timeout for one cycle.
//     undefined -> no watchdog, timeout tied low, ownership unbounded.
module ticket_arbiter #(
  parameter int TKMSB   = 3,
  parameter int HIPROC  = 3,
  parameter int SELMSB  = 1,
  parameter int HOLDMSB = 7
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [HIPROC:0] req,
  output logic [HIPROC:0] grant,
  output logic            busy,
  output logic [SELMSB:0] owner,
  output logic [TKMSB:0]  serving,
  output logic [TKMSB:0]  next_tk,
  output logic            timeout
);

  localparam int NREQ = HIPROC + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_GRANT = 2'd2;

  localparam logic [TKMSB:0] TK_ONE = (TKMSB + 1)'(1);

  // Ticket space must exceed the requester count so that equality against
  // the serving counter can never alias two live tickets, and the owner
  // field must be able to encode HIPROC. A mis-sized configuration lands in
  // this block, which is intentionally empty.
  if (((2 ** (TKMSB + 1)) <= NREQ) || ((2 ** (SELMSB + 1)) <= HIPROC) ||
      (HOLDMSB < 0)) begin : g_bad_params
  end

  // Per-requester state and held ticket
  logic [HIPROC:0][1:0]     r_state;
  logic [HIPROC:0][TKMSB:0] r_ticket;
  logic [HIPROC:0]          r_grant;

  // Shared counters
  logic [TKMSB:0]           r_serving;
  logic [TKMSB:0]           r_next_tk;

  // State decode
  logic [HIPROC:0]          w_idle;
  logic [HIPROC:0]          w_wait;
  logic [HIPROC:0]          w_own;

  // Per-requester events for this edge
  logic [HIPROC:0]          w_raise;
  logic [HIPROC:0]          w_turn;
  logic [HIPROC:0]          w_take;
  logic [HIPROC:0]          w_skip;
  logic [HIPROC:0]          w_drop;
  logic [HIPROC:0]          w_force;
  logic [HIPROC:0]          w_block;

  // Dispenser
  logic [HIPROC:0][TKMSB:0] w_offer;
  logic [TKMSB:0]           w_tk_acc;
  logic [TKMSB:0]           w_next_tk_nxt;

  logic                     w_busy;
  logic                     w_adv;
  logic [SELMSB:0]          w_owner;

  // Decode each requester's state into one-hot-per-requester flags
  always_comb begin
    w_idle = '0;
    w_wait = '0;
    w_own  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idle[i] = (r_state[i] == ST_IDLE);
      w_wait[i] = (r_state[i] == ST_WAIT);
      w_own[i]  = (r_state[i] == ST_GRANT);
    end
  end

  assign w_busy = |r_grant;

  // Classify what each requester does at this edge
  always_comb begin
    w_turn = '0;
    for (int i = 0; i < NREQ; i++) begin
      // Only the waiter holding the serving ticket may act, and only once
      // the resource is free; this yields the one dead cycle on hand-over.
      w_turn[i] = w_wait[i] && (r_ticket[i] == r_serving) && !w_busy;
    end
  end

  assign w_raise = w_idle & req & ~w_block;
  assign w_take  = w_turn & req;
  assign w_skip  = w_turn & ~req;
  assign w_drop  = w_own & ~req;

  // At most one of skip/drop/force can fire per edge: a waiter can only
  // act while nobody owns, and only the owner can drop or be forced.
  assign w_adv = |(w_skip | w_drop | w_force);

  // Hand out consecutive tickets to new arrivals, lowest index first
  always_comb begin
    w_tk_acc = r_next_tk;
    w_offer  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_offer[i] = w_tk_acc;
      if (w_raise[i]) begin
        w_tk_acc = w_tk_acc + TK_ONE;
      end
    end
    w_next_tk_nxt = w_tk_acc;
  end

  // Per-requester FSM, ticket capture and registered grant
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= '0;
      r_ticket <= '0;
      r_grant  <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        case (r_state[i])
          ST_IDLE: begin
            if (w_raise[i]) begin
              r_state[i]  <= ST_WAIT;
              r_ticket[i] <= w_offer[i];
            end
          end
          ST_WAIT: begin
            // Ticket is retained if req drops early; the slot is skipped
            // only when its turn actually comes.
            if (w_take[i]) begin
              r_state[i] <= ST_GRANT;
            end else if (w_skip[i]) begin
              r_state[i] <= ST_IDLE;
            end
          end
          ST_GRANT: begin
            if (w_drop[i] || w_force[i]) begin
              r_state[i] <= ST_IDLE;
            end
          end
          default: begin
            r_state[i] <= ST_IDLE;
          end
        endcase
        r_grant[i] <= w_take[i] | (w_own[i] & req[i] & ~w_force[i]);
      end
    end
  end

  // Now-serving advances whenever a ticket is retired; dispenser follows arrivals
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_serving <= '0;
      r_next_tk <= '0;
    end else begin
      if (w_adv) begin
        r_serving <= r_serving + TK_ONE;
      end
      r_next_tk <= w_next_tk_nxt;
    end
  end

`ifdef GRANT_TIMEOUT_EN
  localparam logic [HOLDMSB:0] HOLD_ONE = (HOLDMSB + 1)'(1);

  logic [HOLDMSB:0] r_hold;
  logic [HIPROC:0]  r_block;
  logic             r_timeout;
  logic             w_hold_hit;

  // r_hold equals the number of cycles the current owner has held grant
  assign w_hold_hit = &r_hold;
  assign w_force    = w_own & req & {NREQ{w_hold_hit}};
  assign w_block    = r_block;

  // Watchdog: restart at 1 on every new grant, count while ownership lasts
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hold <= '0;
    end else if (|w_take) begin
      r_hold <= HOLD_ONE;
    end else if (w_busy) begin
      r_hold <= r_hold + HOLD_ONE;
    end
  end

  // A forced-out requester must lower req once before it may re-enter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_block <= '0;
    end else begin
      r_block <= (r_block & req) | w_force;
    end
  end

  // One-cycle pulse coinciding with the forced grant drop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= |w_force;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_force = '0;
  assign w_block = '0;
  assign timeout = 1'b0;
`endif

  // Binary index of the single granted requester, zero when idle
  always_comb begin
    w_owner = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant[i]) begin
        w_owner = (SELMSB + 1)'(i);
      end
    end
  end

  assign grant   = r_grant;
  assign busy    = w_busy;
  assign owner   = w_owner;
  assign serving = r_serving;
  assign next_tk = r_next_tk;

endmodule
